// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI3 AR/R master port between the instruction-fetch and data-load requesters.
// Define AXI_RD_ARB_RR_EN for round-robin grants; otherwise data has fixed priority over inst.
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_valid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, AR_INST, AR_DATA} state_t;

  state_t state, state_next;
  logic   busy_i, busy_d;
  logic   inst_elig, data_elig;
  logic   grant_inst, grant_data;
  logic   ar_hs, inst_ret, data_ret;
  logic   unused_rresp;

  assign arlen        = 4'd0;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arlock       = 2'd0;
  assign arcache      = 4'd0;
  assign arprot       = 3'd0;
  assign rready       = !rst;
  assign unused_rresp = ^rresp;

  assign arvalid  = (state != IDLE);
  assign ar_hs    = arvalid && arready;
  assign inst_ret = rvalid && rready && rlast && (rid == INST_ID);
  assign data_ret = rvalid && rready && rlast && (rid == DATA_ID);

  // The pulse cycle is excluded so an address the requester is about to change is never issued.
  assign inst_elig = inst_req && !busy_i && !inst_valid;
  assign data_elig = data_req && !busy_d && !data_valid;

`ifdef AXI_RD_ARB_RR_EN
  logic rr_ptr;  // 0: inst wins a tie, 1: data wins a tie

  assign grant_data = data_elig && (!inst_elig || rr_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (ar_hs) begin
      rr_ptr <= (state == AR_INST);
    end
  end
`else
  assign grant_data = data_elig;
`endif
  assign grant_inst = inst_elig && !grant_data;

  // AR channel FSM
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data) begin
          state_next = AR_DATA;
        end else if (grant_inst) begin
          state_next = AR_INST;
        end
      end
      AR_INST, AR_DATA: begin
        if (arready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      araddr <= 32'd0;
      arid   <= 4'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_data) begin
        araddr <= data_addr;
        arid   <= DATA_ID;
      end else if (state == IDLE && grant_inst) begin
        araddr <= inst_addr;
        arid   <= INST_ID;
      end
    end
  end

  // Outstanding flags: set by the AR handshake, cleared by the matching last R beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_i <= 1'b0;
      busy_d <= 1'b0;
    end else begin
      if (ar_hs && state == AR_INST) begin
        busy_i <= 1'b1;
      end else if (inst_ret) begin
        busy_i <= 1'b0;
      end
      if (ar_hs && state == AR_DATA) begin
        busy_d <= 1'b1;
      end else if (data_ret) begin
        busy_d <= 1'b0;
      end
    end
  end

  // R return stage: only beats for a read still outstanding reach a requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      inst_valid <= inst_ret && busy_i;
      data_valid <= data_ret && busy_d;
      if (inst_ret && busy_i) begin
        inst_rdata <= rdata;
      end
      if (data_ret && busy_d) begin
        data_rdata <= rdata;
      end
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel arbiter that shares one AXI3 AR/R master port between the instruction-fetch requester and the data-load requester of the CPU core. It sits between the core's request ports and the AXI master interface, issuing single-beat 32-bit reads tagged by requester ID. It tracks one outstanding read per requester, up to two in total, and steers each R response back to its owner with a registered valid pulse.

## Interface
Parameters:
- INST_ID, 4'd0, ARID used for instruction reads.
- DATA_ID, 4'd1, ARID used for data reads.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction read request (level).
- inst_addr  in  32  instruction read address.
- inst_valid  out  1  one-cycle pulse: inst_rdata is valid.
- inst_rdata  out  32  instruction read data.
- data_req  in  1  data read request (level).
- data_addr  in  32  data read address.
- data_valid  out  1  one-cycle pulse: data_rdata is valid.
- data_rdata  out  32  data read data.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/4/3/2/2/4/3  AXI3 AR payload.
- arvalid  out  1, arready  in  1  AR handshake.
- rid/rdata/rresp/rlast  in  4/32/2/1  AXI3 R payload.
- rvalid  in  1, rready  out  1  R handshake.

## Operation
- Constant AR fields: arlen=0, arsize=3'b010, arburst=2'b01, arlock=0, arcache=0, arprot=0.
- rready = !rst. The arbiter never stalls R.
- Requester contract: hold req and addr stable from assertion until that requester's valid pulse. The requester may change addr on the cycle after the valid pulse.
- Per-requester outstanding flags busy_i and busy_d:
  - Set on the AR handshake with the matching arid.
  - Cleared on rvalid&&rready&&rlast with the matching rid.
- Eligibility: req && !busy && !valid_out (the valid pulse cycle is excluded so a stale addr is never issued).
- AR FSM, states IDLE, AR_INST, AR_DATA:
  - IDLE: select an eligible requester per the policy in Configuration, latch its addr into araddr, go to AR_INST or AR_DATA. With no eligible requester, stay in IDLE.
  - AR_INST / AR_DATA: arvalid=1, arid=INST_ID/DATA_ID. araddr and arid stay stable until arready. On arready, go to IDLE.
  - arvalid is never withdrawn before arready.
- R return:
  - rid==INST_ID: register rdata into inst_rdata and pulse inst_valid on the next cycle.
  - rid==DATA_ID: same, into data_rdata and data_valid.
  - Any other rid: dropped, no pulse, flags unchanged.
- rresp is ignored; data is returned regardless of rresp.
- A response with rlast=0 is illegal (single-beat only). Behaviour is undefined and not verified.

## Timing
- Reset values: arvalid=0, araddr=0, arid=0, inst_valid=0, data_valid=0, inst_rdata=0, data_rdata=0, rready=0 while rst is high. FSM=IDLE, busy_i=busy_d=0, rr pointer=inst.
- Request accepted in IDLE at cycle N: arvalid=1 at N+1.
- R handshake at cycle M: *_valid=1 and *_rdata valid at M+1, and the busy flag is clear from M+1.
- Earliest re-issue by the same requester: valid pulse at M+1, so IDLE evaluates at M+2 and arvalid rises at M+3.
- Simultaneous events:
  - An R return for one requester and an AR handshake for the other in the same cycle are both honoured.
  - Both requesters eligible in IDLE: policy decides.
  - busy_d set and busy_i cleared in the same cycle: each flag is updated independently.
- Reset mid-transaction: all state returns to reset values. Late R beats for pre-reset reads arrive with busy clear and produce no valid pulse.

## Configuration
- AXI_RD_ARB_RR_EN defined:
  - Round-robin between inst and data.
  - The 1-bit pointer flips to the other requester after each AR handshake.
  - When both are eligible, the requester not granted last wins.
- Undefined: fixed priority, data over inst. The pointer logic is absent.

## Test plan
- Single inst read: inst_req=1, addr=0x10, arready=1, R returns rid=0, rdata=0xDEADBEEF two cycles later -> arid=0, araddr=0x10, arlen=0. inst_valid pulses exactly one cycle with 0xDEADBEEF. The next AR (addr 0x14) rises no earlier than 2 cycles after the pulse.
- Both requesters request in the same cycle (inst 0x100, data 0x200):
  - Fixed build: data AR first (arid=1, 0x200), then inst.
  - RR build: the first grant follows the pointer (inst after reset), the next alternates.
- Out-of-order return: issue inst then data; R returns rid=1 (0x2222) before rid=0 (0x1111) -> data_valid with 0x2222 precedes inst_valid with 0x1111, no cross-talk.
- Backpressure: arready held low for 5 cycles -> arvalid, araddr and arid stay constant for all 5 cycles. Exactly one handshake occurs, and busy is set once.
- Stray response: rvalid with rid=4'd7 -> no valid pulse, busy flags unchanged.
- Reset mid-operation: assert rst while a read is outstanding, then deliver its R beat after reset deasserts -> no valid pulse, arvalid=0 until a new request.
